// File: rtl/csr_access_unit.sv
// Zicsr initiator: reads the CSR in EX, computes the new value, retires through a one-entry WB register.
// Optional macro CSR_RO_CHECK_EN turns write intent to the read-only CSR space into an illegal instruction.
module csr_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int SER_CYCLES     = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [2:0]                op_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [4:0]                rs1_uimm_i,
    input  logic [4:0]                rd_addr_i,
    input  logic                      flush_i,
    input  logic                      wb_stall_i,
    output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
    input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      rd_we_o,
    output logic [4:0]                rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rd_wdata_o,
    output logic                      instret_incr_o,
    output logic                      illegal_o
);

    // funct3[1:0] selects the operation; funct3[2] only selects the immediate source.
    typedef enum logic [1:0] {
        OP_ILL = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } csr_op_e;

    csr_op_e               op_kind;
    logic [DATA_WIDTH-1:0] src;
    logic [DATA_WIDTH-1:0] new_val;
    logic                  write_intent;
    logic                  is_illegal;
    logic                  accept;
    logic                  wb_live;

    logic [2:0]                ser_cnt;
    logic                      wb_valid;
    logic                      wb_csr_we;
    logic                      wb_rd_we;
    logic                      wb_illegal;
    logic [CSR_ADDR_WIDTH-1:0] wb_waddr;
    logic [DATA_WIDTH-1:0]     wb_wdata;
    logic [4:0]                wb_rd_addr;
    logic [DATA_WIDTH-1:0]     wb_rd_wdata;

    assign op_kind     = csr_op_e'(op_i[1:0]);
    assign csr_raddr_o = csr_addr_i;
    assign ready_o     = !wb_stall_i && !flush_i && (ser_cnt == 3'd0);
    assign accept      = valid_i && ready_o;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        src          = op_i[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_uimm_i} : rs1_data_i;
        new_val      = src;
        write_intent = 1'b0;
        is_illegal   = 1'b0;
        case (op_kind)
            OP_RW: begin
                new_val      = src;
                write_intent = 1'b1;
            end
            OP_RS: begin
                new_val      = csr_rdata_i | src;
                write_intent = (rs1_uimm_i != 5'd0);
            end
            OP_RC: begin
                new_val      = csr_rdata_i & ~src;
                write_intent = (rs1_uimm_i != 5'd0);
            end
            OP_ILL: begin
                is_illegal = 1'b1;
            end
        endcase
`ifdef CSR_RO_CHECK_EN
        if (write_intent && (csr_addr_i[CSR_ADDR_WIDTH-1 -: 2] == 2'b11))
            is_illegal = 1'b1;
`endif
    end

    // Enables are qualified here so a stalled or flushed entry never fires twice.
    assign wb_live        = wb_valid && !wb_stall_i && !flush_i;
    assign csr_we_o       = wb_live && wb_csr_we;
    assign rd_we_o        = wb_live && wb_rd_we;
    assign instret_incr_o = wb_live && !wb_illegal;
    assign illegal_o      = wb_live && wb_illegal;
    assign csr_waddr_o    = wb_waddr;
    assign csr_wdata_o    = wb_wdata;
    assign rd_addr_o      = wb_rd_addr;
    assign rd_wdata_o     = wb_rd_wdata;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // NOTE: data fields are reset too because they are visible on the outputs after reset.
            ser_cnt     <= 3'd0;
            wb_valid    <= 1'b0;
            wb_csr_we   <= 1'b0;
            wb_rd_we    <= 1'b0;
            wb_illegal  <= 1'b0;
            wb_waddr    <= '0;
            wb_wdata    <= '0;
            wb_rd_addr  <= 5'd0;
            wb_rd_wdata <= '0;
        end else if (flush_i) begin
            wb_valid <= 1'b0;
            ser_cnt  <= 3'd0;
        end else if (!wb_stall_i) begin
            wb_valid <= accept;
            if (accept) begin
                wb_csr_we   <= write_intent && !is_illegal;
                wb_rd_we    <= (rd_addr_i != 5'd0) && !is_illegal;
                wb_illegal  <= is_illegal;
                wb_waddr    <= csr_addr_i;
                wb_wdata    <= new_val;
                wb_rd_addr  <= rd_addr_i;
                wb_rd_wdata <= csr_rdata_i;
            end
            if (accept && write_intent && !is_illegal)
                ser_cnt <= 3'(SER_CYCLES);
            else if (ser_cnt != 3'd0)
                ser_cnt <= ser_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: two instances (SER_CYCLES 1 and 3) share stimulus and are
// checked every cycle against an instruction-level model, plus directed literal checks.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] rs1_data_i;
    logic [4:0]  rs1_uimm_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        wb_stall_i;
    logic [31:0] csr_rdata_i;

    logic        ready    [2];
    logic [11:0] raddr    [2];
    logic        csr_we   [2];
    logic [11:0] waddr    [2];
    logic [31:0] wdata    [2];
    logic        rd_we    [2];
    logic [4:0]  rd_addr  [2];
    logic [31:0] rd_wdata [2];
    logic        instret  [2];
    logic        illegal  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    csr_access_unit #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12), .SER_CYCLES(1)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready[0]),
        .op_i(op_i), .csr_addr_i(csr_addr_i), .rs1_data_i(rs1_data_i),
        .rs1_uimm_i(rs1_uimm_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .wb_stall_i(wb_stall_i), .csr_raddr_o(raddr[0]), .csr_rdata_i(csr_rdata_i),
        .csr_we_o(csr_we[0]), .csr_waddr_o(waddr[0]), .csr_wdata_o(wdata[0]),
        .rd_we_o(rd_we[0]), .rd_addr_o(rd_addr[0]), .rd_wdata_o(rd_wdata[0]),
        .instret_incr_o(instret[0]), .illegal_o(illegal[0])
    );

    csr_access_unit #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12), .SER_CYCLES(3)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready[1]),
        .op_i(op_i), .csr_addr_i(csr_addr_i), .rs1_data_i(rs1_data_i),
        .rs1_uimm_i(rs1_uimm_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .wb_stall_i(wb_stall_i), .csr_raddr_o(raddr[1]), .csr_rdata_i(csr_rdata_i),
        .csr_we_o(csr_we[1]), .csr_waddr_o(waddr[1]), .csr_wdata_o(wdata[1]),
        .rd_we_o(rd_we[1]), .rd_addr_o(rd_addr[1]), .rd_wdata_o(rd_wdata[1]),
        .instret_incr_o(instret[1]), .illegal_o(illegal[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef struct packed {
        logic        v;
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  uimm;
        logic [4:0]  rd;
        logic [31:0] old;
    } ent_t;

    ent_t ent   [2];
    int   bub   [2];
    bit   fresh [2];
    int   ser_of [2] = '{1, 3};

    function automatic logic m_writes(input ent_t e);
        case (e.op)
            3'b001, 3'b101:                 return 1'b1;
            3'b010, 3'b011, 3'b110, 3'b111: return e.uimm != 5'd0;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic m_illegal(input ent_t e);
        logic [11:0] a;
        a = e.addr;
        if (e.op == 3'b000 || e.op == 3'b100) return 1'b1;
`ifdef CSR_RO_CHECK_EN
        if (m_writes(e) && a[11:10] == 2'b11) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_newval(input ent_t e);
        logic [31:0] zimm;
        zimm = {27'd0, e.uimm};
        case (e.op)
            3'b001:  return e.rs1;
            3'b101:  return zimm;
            3'b010:  return e.old | e.rs1;
            3'b110:  return e.old | zimm;
            3'b011:  return e.old & ~e.rs1;
            3'b111:  return e.old & ~zimm;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n_i) begin
            for (int k = 0; k < 2; k++) begin
                logic live, ill;
                live = ent[k].v && !wb_stall_i && !flush_i;
                ill  = m_illegal(ent[k]);
                check($sformatf("u%0d ready", k), ready[k],
                      !wb_stall_i && !flush_i && bub[k] == 0);
                check($sformatf("u%0d raddr", k), raddr[k], csr_addr_i);
                check($sformatf("u%0d csr_we", k), csr_we[k], live && !ill && m_writes(ent[k]));
                check($sformatf("u%0d rd_we", k), rd_we[k], live && !ill && ent[k].rd != 0);
                check($sformatf("u%0d instret", k), instret[k], live && !ill);
                check($sformatf("u%0d illegal", k), illegal[k], live && ill);
                if (fresh[k]) begin
                    check($sformatf("u%0d waddr rst", k), waddr[k], 0);
                    check($sformatf("u%0d wdata rst", k), wdata[k], 0);
                    check($sformatf("u%0d rd_addr rst", k), rd_addr[k], 0);
                    check($sformatf("u%0d rd_wdata rst", k), rd_wdata[k], 0);
                end else if (ent[k].v && !ill) begin
                    check($sformatf("u%0d waddr", k), waddr[k], ent[k].addr);
                    check($sformatf("u%0d wdata", k), wdata[k], m_newval(ent[k]));
                    check($sformatf("u%0d rd_addr", k), rd_addr[k], ent[k].rd);
                    check($sformatf("u%0d rd_wdata", k), rd_wdata[k], ent[k].old);
                end
            end
        end
        // advance the model with the inputs that the coming edge will sample
        for (int k = 0; k < 2; k++) begin
            if (!rst_n_i) begin
                ent[k]   = '0;
                bub[k]   = 0;
                fresh[k] = 1'b1;
            end else if (flush_i) begin
                ent[k].v = 1'b0;
                bub[k]   = 0;
            end else if (!wb_stall_i) begin
                if (valid_i && bub[k] == 0) begin
                    ent[k] = '{v: 1'b1, op: op_i, addr: csr_addr_i, rs1: rs1_data_i,
                               uimm: rs1_uimm_i, rd: rd_addr_i, old: csr_rdata_i};
                    fresh[k] = 1'b0;
                    if (!m_illegal(ent[k]) && m_writes(ent[k])) bub[k] = ser_of[k];
                end else begin
                    ent[k].v = 1'b0;
                    if (bub[k] > 0) bub[k]--;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] uimm, input logic [4:0] rd, input logic [31:0] rdata);
        valid_i     = 1'b1;
        op_i        = op;
        csr_addr_i  = addr;
        rs1_data_i  = rs1;
        rs1_uimm_i  = uimm;
        rd_addr_i   = rd;
        csr_rdata_i = rdata;
    endtask

    task automatic idle();
        valid_i = 1'b0;
    endtask

    initial begin
        rst_n_i = 1'b0; valid_i = 1'b0; op_i = 3'b000; csr_addr_i = 12'h0;
        rs1_data_i = 32'h0; rs1_uimm_i = 5'd0; rd_addr_i = 5'd0;
        flush_i = 1'b0; wb_stall_i = 1'b0; csr_rdata_i = 32'h0;

        repeat (4) step();
        rst_n_i = 1'b1;
        @(negedge clk);
        check("rst ready", ready[0], 1);
        check("rst csr_we", csr_we[0], 0);
        check("rst rd_wdata", rd_wdata[0], 0);

        // CSRRW rd=5, 0x340 <- 0xDEADBEEF, old 0
        step(); drive(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd5, 32'h0);
        step(); idle();
        @(negedge clk);
        check("rw csr_we", csr_we[0], 1);
        check("rw waddr", waddr[0], 32'h340);
        check("rw wdata", wdata[0], 32'hDEADBEEF);
        check("rw rd_we", rd_we[0], 1);
        check("rw rd_addr", rd_addr[0], 5);
        check("rw rd_wdata", rd_wdata[0], 0);
        check("rw instret", instret[0], 1);
        check("rw bubble", ready[0], 0);

        // CSRRS rd=6, 0x300, rs1=x0 -> read only
        step(); drive(3'b010, 12'h300, 32'h0, 5'd0, 5'd6, 32'h1888);
        step(); idle();
        @(negedge clk);
        check("rs csr_we", csr_we[0], 0);
        check("rs rd_we", rd_we[0], 1);
        check("rs rd_wdata", rd_wdata[0], 32'h1888);
        check("rs instret", instret[0], 1);
        check("rs no bubble", ready[0], 1);

        // CSRRCI rd=0, 0x304, zimm=8, old 0x888
        step(); drive(3'b111, 12'h304, 32'hFFFF_FFFF, 5'd8, 5'd0, 32'h888);
        step(); idle();
        @(negedge clk);
        check("rci csr_we", csr_we[0], 1);
        check("rci wdata", wdata[0], 32'h880);
        check("rci rd_we", rd_we[0], 0);
        step();

        // CSRRW to read-only space 0xC00
        step(); drive(3'b001, 12'hC00, 32'h1234, 5'd3, 5'd7, 32'h55);
        step(); idle();
        @(negedge clk);
`ifdef CSR_RO_CHECK_EN
        check("ro illegal", illegal[0], 1);
        check("ro csr_we", csr_we[0], 0);
        check("ro instret", instret[0], 0);
`else
        check("ro illegal", illegal[0], 0);
        check("ro csr_we", csr_we[0], 1);
        check("ro instret", instret[0], 1);
`endif
        step();

        // stall the WB entry for three cycles
        step(); drive(3'b001, 12'h341, 32'hA5A5A5A5, 5'd2, 5'd9, 32'h77);
        for (int i = 0; i < 3; i++) begin
            step(); idle(); wb_stall_i = 1'b1;
            @(negedge clk);
            check("stall csr_we", csr_we[0], 0);
            check("stall instret", instret[0], 0);
            check("stall ready", ready[0], 0);
            check("stall waddr hold", waddr[0], 32'h341);
        end
        step(); wb_stall_i = 1'b0;
        @(negedge clk);
        check("unstall csr_we", csr_we[0], 1);
        check("unstall instret", instret[0], 1);
        check("unstall ready", ready[0], 0);
        step();
        @(negedge clk);
        check("post csr_we", csr_we[0], 0);
        check("post instret", instret[0], 0);
        check("post ready", ready[0], 1);

        // flush while the entry is valid
        step(); drive(3'b001, 12'h342, 32'h1, 5'd1, 5'd3, 32'h0);
        step(); idle(); flush_i = 1'b1;
        @(negedge clk);
        check("flush csr_we", csr_we[0], 0);
        check("flush instret", instret[0], 0);
        check("flush ready", ready[0], 0);
        step(); flush_i = 1'b0;
        @(negedge clk);
        check("after flush csr_we", csr_we[0], 0);
        check("after flush ready", ready[0], 1);

        // illegal funct3 100
        step(); drive(3'b100, 12'h305, 32'h9, 5'd9, 5'd2, 32'h3);
        step(); idle();
        @(negedge clk);
        check("ill illegal", illegal[0], 1);
        check("ill rd_we", rd_we[0], 0);
        check("ill instret", instret[0], 0);

        // back-to-back mixed traffic, checked by the model only
        step(); drive(3'b110, 12'h300, 32'h0, 5'd5, 5'd1, 32'h100);
        step(); drive(3'b011, 12'h344, 32'hF0, 5'd4, 5'd2, 32'hFF);
        step(); drive(3'b000, 12'h344, 32'h0, 5'd1, 5'd3, 32'h1);
        step(); drive(3'b010, 12'h343, 32'h0F00, 5'd7, 5'd4, 32'h00F0);
        step(); drive(3'b101, 12'hC01, 32'h0, 5'd31, 5'd5, 32'h42);
        step(); wb_stall_i = 1'b1; drive(3'b011, 12'h345, 32'h3, 5'd0, 5'd6, 32'h7);
        step(); wb_stall_i = 1'b0;
        step(); flush_i = 1'b1;
        step(); flush_i = 1'b0; idle();
        repeat (5) step();

        // reset the SER_CYCLES=3 instance mid-count
        drive(3'b001, 12'h343, 32'hFFFF0000, 5'd1, 5'd4, 32'h12);
        step(); idle();
        @(negedge clk);
        check("u1 counting", ready[1], 0);
        check("u1 csr_we", csr_we[1], 1);
        step(); rst_n_i = 1'b0;
        step();
        step(); rst_n_i = 1'b1;
        @(negedge clk);
        check("u1 rst ready", ready[1], 1);
        check("u1 rst csr_we", csr_we[1], 0);
        check("u1 rst waddr", waddr[1], 0);
        check("u1 rst wdata", wdata[1], 0);
        check("u1 rst instret", instret[1], 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
